accumulator_register: RTL and testbench

//   Parametrised accumulator register for the MAC datapath. Each enabled cycle it either loads the input
//   or adds it into the stored value, with a wrap/saturate policy and a sticky overflow flag.
//   It also keeps an update counter and a one-cycle valid strobe so downstream logic knows when acc_out changed.
//   It sits after the adder/multiplier stage and holds the running MAC result between operations.
//

---
 rtl/accumulator_register_if.sv | 27 ++
 rtl/accumulator_register.sv | 76 +++++++
 tb/tb_accumulator_register.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/accumulator_register_if.sv
// Operand/result bundle for accumulator_register.
// master: the producer driving enable/mode/clear/data_in and observing the result.
// slave:  the accumulator itself.
interface accumulator_register_if #(
    parameter int WIDTH     = 16,
    parameter int IN_WIDTH  = 8,
    parameter int CNT_WIDTH = 8
);
    logic                 enable;
    logic                 mode;
    logic                 clear;
    logic [IN_WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]     acc_out;
    logic                 overflow;
    logic [CNT_WIDTH-1:0] count;
    logic                 valid_out;

    modport master (
        output enable, mode, clear, data_in,
        input  acc_out, overflow, count, valid_out
    );

    modport slave (
        input  enable, mode, clear, data_in,
        output acc_out, overflow, count, valid_out
    );
endinterface

// File: rtl/accumulator_register.sv
// Accumulator register for the MAC datapath.
// Each enabled cycle either loads data_in (mode=0) or adds it into the stored
// value (mode=1). Keeps a sticky carry-out flag, a saturating update counter
// and a one-cycle valid strobe. All outputs come straight from flops.
// Build option: define SATURATE_EN to clamp acc_out at all-ones on carry-out;
// without it the sum wraps modulo 2**WIDTH.
module accumulator_register #(
    parameter int WIDTH     = 16,
    parameter int IN_WIDTH  = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    accumulator_register_if.slave bus
);

    if (IN_WIDTH > WIDTH) begin : g_width_check
        $error("accumulator_register: IN_WIDTH must not exceed WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     acc_q;
    logic                 ovf_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 valid_q;

    // Operand zero-extended to WIDTH+1 so the carry lands in the top bit.
    logic [WIDTH:0] data_ext;
    logic [WIDTH:0] sum;

    assign data_ext = {{(WIDTH + 1 - IN_WIDTH){1'b0}}, bus.data_in};
    assign sum      = {1'b0, acc_q} + data_ext;

    // Accumulator state update: clear beats enable, enable beats hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.clear) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.enable) begin
            valid_q <= 1'b1;
            if (!bus.mode) begin
                acc_q <= data_ext[WIDTH-1:0];
                ovf_q <= 1'b0;
                cnt_q <= CNT_ONE;
            end else begin
                ovf_q <= ovf_q | sum[WIDTH];
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
`ifdef SATURATE_EN
                // Once clamped, any further non-zero add carries again, so it stays clamped.
                acc_q <= sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                acc_q <= sum[WIDTH-1:0];
`endif
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.acc_out   = acc_q;
    assign bus.overflow  = ovf_q;
    assign bus.count     = cnt_q;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_accumulator_register.sv
// Directed self-checking bench for accumulator_register (WIDTH=8, IN_WIDTH=8, CNT_WIDTH=4).
// Observed state is packed as {acc_out, overflow, count, valid_out}.
module tb_accumulator_register;
    localparam int WIDTH     = 8;
    localparam int IN_WIDTH  = 8;
    localparam int CNT_WIDTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    accumulator_register_if #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    accumulator_register #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [13:0] obs;
    logic [13:0] exp_v;
    assign obs = {bus.acc_out, bus.overflow, bus.count, bus.valid_out};

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Drive one cycle of stimulus; returns at the following negedge, after the active edge.
    task automatic cyc(input logic en, input logic md, input logic clr, input logic [7:0] d);
        bus.enable  = en;
        bus.mode    = md;
        bus.clear   = clr;
        bus.data_in = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        exp_v = {8'h00, 1'b0, 4'd0, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL reset_initial got=%h exp=%h", obs, exp_v); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 0, 8'h30);
        exp_v = {8'h30, 1'b0, 4'd1, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL reset_pre_load got=%h exp=%h", obs, exp_v); else n_pass++;
        cyc(1, 1, 0, 8'h07);
        exp_v = {8'h37, 1'b0, 4'd2, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL reset_pre_acc got=%h exp=%h", obs, exp_v); else n_pass++;
        // Keep accumulating, then hit reset between edges.
        bus.data_in = 8'h05;
        #2 reset = 1'b1;
        #1;
        exp_v = {8'h00, 1'b0, 4'd0, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL reset_async got=%h exp=%h", obs, exp_v); else n_pass++;
        @(negedge clk);
        n_total++; if (obs !== exp_v) $display("FAIL reset_held got=%h exp=%h", obs, exp_v); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_load_accumulate();
        cyc(1, 0, 0, 8'h10);
        exp_v = {8'h10, 1'b0, 4'd1, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL load_10 got=%h exp=%h", obs, exp_v); else n_pass++;
        cyc(1, 1, 0, 8'h05);
        exp_v = {8'h15, 1'b0, 4'd2, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL acc_05 got=%h exp=%h", obs, exp_v); else n_pass++;
        cyc(1, 1, 0, 8'h03);
        exp_v = {8'h18, 1'b0, 4'd3, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL acc_03 got=%h exp=%h", obs, exp_v); else n_pass++;
        cyc(0, 1, 0, 8'hAA);
        exp_v = {8'h18, 1'b0, 4'd3, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL valid_drop got=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_overflow();
        cyc(1, 0, 0, 8'd200);
        exp_v = {8'd200, 1'b0, 4'd1, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL ovf_load200 got=%h exp=%h", obs, exp_v); else n_pass++;
        cyc(1, 1, 0, 8'd100);
        exp_v = {(SAT ? 8'd255 : 8'd44), 1'b1, 4'd2, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL ovf_acc100 got=%h exp=%h", obs, exp_v); else n_pass++;
        cyc(1, 1, 0, 8'd1);
        exp_v = {(SAT ? 8'd255 : 8'd45), 1'b1, 4'd3, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL ovf_sticky got=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_count_saturation();
        cyc(1, 0, 0, 8'h01);
        exp_v = {8'h01, 1'b0, 4'd1, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL cnt_load got=%h exp=%h", obs, exp_v); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 8'h01);
            if (i == 13) begin
                exp_v = {8'h0F, 1'b0, 4'd15, 1'b1};
                n_total++; if (obs !== exp_v) $display("FAIL cnt_reach15 got=%h exp=%h", obs, exp_v); else n_pass++;
            end
        end
        exp_v = {8'h15, 1'b0, 4'd15, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL cnt_hold15 got=%h exp=%h", obs, exp_v); else n_pass++;
        cyc(1, 1, 0, 8'hFF);
        exp_v = {(SAT ? 8'hFF : 8'h14), 1'b1, 4'd15, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL cnt_ovf got=%h exp=%h", obs, exp_v); else n_pass++;
        cyc(1, 0, 0, 8'h02);
        exp_v = {8'h02, 1'b0, 4'd1, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL cnt_reload got=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_clear_priority();
        cyc(1, 1, 0, 8'hFF);
        exp_v = {(SAT ? 8'hFF : 8'h01), 1'b1, 4'd2, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL clr_setup got=%h exp=%h", obs, exp_v); else n_pass++;
        cyc(1, 1, 1, 8'h7F);
        exp_v = {8'h00, 1'b0, 4'd0, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL clr_over_en got=%h exp=%h", obs, exp_v); else n_pass++;
        cyc(0, 0, 0, 8'h00);
        n_total++; if (obs !== exp_v) $display("FAIL clr_after got=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_hold();
        cyc(1, 0, 0, 8'h5A);
        exp_v = {8'h5A, 1'b0, 4'd1, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL hold_load got=%h exp=%h", obs, exp_v); else n_pass++;
        cyc(1, 1, 0, 8'hC0);
        exp_v = {(SAT ? 8'hFF : 8'h1A), 1'b1, 4'd2, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL hold_acc got=%h exp=%h", obs, exp_v); else n_pass++;
        exp_v = {(SAT ? 8'hFF : 8'h1A), 1'b1, 4'd2, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 0, 8'($urandom_range(0, 255)));
            n_total++; if (obs !== exp_v) $display("FAIL hold_cycle%0d got=%h exp=%h", i, obs, exp_v); else n_pass++;
        end
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.mode    = 1'b0;
        bus.clear   = 1'b0;
        bus.data_in = '0;
        #1;
        test_reset();
        test_load_accumulate();
        test_overflow();
        test_count_saturation();
        test_clear_priority();
        test_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
